// File: rtl/sample_dac_spi_tx.sv
// Sample-to-DAC SPI transmitter: captures 12-bit signed samples, sends 16-bit MCP4921 frames.
// Optional macro SAMPLE_DAC_LDAC_EN: drive a one-clock LDAC_n pulse instead of tying LDAC_n low.
module sample_dac_spi_tx #(
    parameter int          CLK_DIV       = 4,
    parameter logic [3:0]  CONFIG_NIBBLE = 4'b0011
) (
    input  logic        inCLK_50MHZ,
    input  logic        inRESET,
    input  logic [11:0] inSample,
    input  logic        inSampleReady,
    output logic        outDAC_CS_n,
    output logic        outDAC_SCK,
    output logic        outDAC_MOSI,
    output logic        outDAC_LDAC_n,
    output logic        outBusy,
    output logic        outOverrun
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam int             CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);

    state_t        state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [3:0]    bitCnt, bitCntNext;
    logic [15:0]   shiftReg, shiftNext;
    logic [11:0]   holdReg, holdNext;
    logic          pending, pendingNext;
    logic          overrun, overrunNext;
    logic          csN, csNext;
    logic          sck, sckNext;
    logic          mosi, mosiNext;
    logic          phaseDone;
    logic [11:0]   sampleOb;
    logic [15:0]   frameWord;

    assign phaseDone = (cnt == CNT_LAST);
    assign sampleOb  = inSample ^ 12'h800;
    // A strobe in IDLE is sent directly, bypassing the hold register.
    assign frameWord = {CONFIG_NIBBLE, inSampleReady ? sampleOb : holdReg};

    // NOTE: every next-value gets a default first so this block never infers a latch.
    always_comb begin
        stateNext   = state;
        cntNext     = phaseDone ? '0 : cnt + 1'b1;
        bitCntNext  = bitCnt;
        shiftNext   = shiftReg;
        holdNext    = holdReg;
        pendingNext = pending;
        overrunNext = overrun | (inSampleReady & pending);
        csNext      = csN;
        sckNext     = sck;
        mosiNext    = mosi;

        if (inSampleReady) begin
            holdNext    = sampleOb;
            pendingNext = 1'b1;
        end

        case (state)
            IDLE: begin
                cntNext = '0;
                if (pending || inSampleReady) begin
                    shiftNext   = frameWord;
                    mosiNext    = frameWord[15];
                    bitCntNext  = 4'd15;
                    pendingNext = 1'b0;
                    csNext      = 1'b0;
                    stateNext   = SETUP;
                end
            end
            SETUP: begin
                if (phaseDone) begin
                    sckNext   = 1'b1;
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (phaseDone) begin
                    if (sck) begin
                        sckNext = 1'b0;
                        if (bitCnt == 4'd0) begin
                            stateNext = HOLD;
                        end else begin
                            bitCntNext = bitCnt - 4'd1;
                            shiftNext  = {shiftReg[14:0], 1'b0};
                            mosiNext   = shiftReg[14];
                        end
                    end else begin
                        sckNext = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (phaseDone) begin
                    csNext    = 1'b1;
                    stateNext = GAP;
                end
            end
            GAP: begin
                if (phaseDone) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge inCLK_50MHZ) begin
        if (inRESET) begin
            state    <= IDLE;
            cnt      <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            holdReg  <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
            csN      <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftNext;
            holdReg  <= holdNext;
            pending  <= pendingNext;
            overrun  <= overrunNext;
            csN      <= csNext;
            sck      <= sckNext;
            mosi     <= mosiNext;
        end
    end

`ifdef SAMPLE_DAC_LDAC_EN
    logic ldacN;

    // Low for one clock, starting one clock after CS_n rises.
    always_ff @(posedge inCLK_50MHZ) begin
        if (inRESET) ldacN <= 1'b1;
        else         ldacN <= !(state == GAP && cnt == '0);
    end

    assign outDAC_LDAC_n = ldacN;
`else
    assign outDAC_LDAC_n = 1'b0;
`endif

    assign outDAC_CS_n = csN;
    assign outDAC_SCK  = sck;
    assign outDAC_MOSI = mosi;
    assign outBusy     = (state != IDLE);
    assign outOverrun  = overrun;

endmodule

// File: tb/tb_sample_dac_spi_tx.sv
// Self-checking bench for sample_dac_spi_tx: SPI monitor plus expected-frame scoreboard.
module tb_sample_dac_spi_tx;

    logic        inCLK_50MHZ = 1'b0;
    logic        inRESET = 1'b1;
    logic [11:0] inSample = '0;
    logic        inSampleReady = 1'b0;
    logic        outDAC_CS_n, outDAC_SCK, outDAC_MOSI, outDAC_LDAC_n, outBusy, outOverrun;

    int vectors = 0;
    int miscompares = 0;

    sample_dac_spi_tx #(.CLK_DIV(4), .CONFIG_NIBBLE(4'b0011)) dut (
        .inCLK_50MHZ  (inCLK_50MHZ),
        .inRESET      (inRESET),
        .inSample     (inSample),
        .inSampleReady(inSampleReady),
        .outDAC_CS_n  (outDAC_CS_n),
        .outDAC_SCK   (outDAC_SCK),
        .outDAC_MOSI  (outDAC_MOSI),
        .outDAC_LDAC_n(outDAC_LDAC_n),
        .outBusy      (outBusy),
        .outOverrun   (outOverrun)
    );

    always #10 inCLK_50MHZ = ~inCLK_50MHZ;

    // Scoreboard and monitor queues; one entry per completed CS_n-low window.
    logic [15:0] expQ[$];
    logic [15:0] gotFrame[$];
    int          gotRises[$];
    int          gotCsLow[$];
    int          gotGap[$];

    logic [15:0] monBits = '0;
    int          monRises = 0, monCsLow = 0, monCsHigh = 0, monGap = 0;
    int          totalRises = 0, ldacHigh = 0;
    logic        sckPrev = 1'b0, csPrev = 1'b1;

    always @(negedge inCLK_50MHZ) begin
        if (outDAC_CS_n === 1'b0 && csPrev === 1'b1) begin
            monGap   = monCsHigh;
            monBits  = '0;
            monRises = 0;
            monCsLow = 0;
        end
        if (outDAC_CS_n === 1'b0) monCsLow++;
        else                      monCsHigh++;
        if (outDAC_CS_n === 1'b0 && csPrev === 1'b1) monCsHigh = 0;
        if (outDAC_SCK === 1'b1 && sckPrev !== 1'b1) begin
            monBits = {monBits[14:0], outDAC_MOSI};
            monRises++;
            totalRises++;
        end
        if (outDAC_CS_n === 1'b1 && csPrev === 1'b0) begin
            gotFrame.push_back(monBits);
            gotRises.push_back(monRises);
            gotCsLow.push_back(monCsLow);
            gotGap.push_back(monGap);
            monCsHigh = 1;
        end
        if (!inRESET && outDAC_LDAC_n !== 1'b0) ldacHigh++;
        sckPrev = outDAC_SCK;
        csPrev  = outDAC_CS_n;
    end

    // SCK must never be high while chip select is released.
    int sckWhileIdle = 0;
    always @(negedge inCLK_50MHZ) begin
        if (!inRESET && outDAC_CS_n === 1'b1 && outDAC_SCK !== 1'b0) sckWhileIdle++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic [11:0] s);
        inSample      = s;
        inSampleReady = 1'b1;
        @(negedge inCLK_50MHZ);
        inSampleReady = 1'b0;
    endtask

    task automatic push_exp(input logic [11:0] s);
        expQ.push_back({4'b0011, s ^ 12'h800});
    endtask

    task automatic get_frame(output bit ok, output logic [15:0] f, output int rises,
                             output int csLow, output int gap, output logic [15:0] exp);
        int n = 0;
        while (gotFrame.size() == 0 && n < 400) begin
            @(negedge inCLK_50MHZ);
            n++;
        end
        ok = (gotFrame.size() != 0) && (expQ.size() != 0);
        f = '0; rises = 0; csLow = 0; gap = 0; exp = 'x;
        if (ok) begin
            f     = gotFrame.pop_front();
            rises = gotRises.pop_front();
            csLow = gotCsLow.pop_front();
            gap   = gotGap.pop_front();
            exp   = expQ.pop_front();
        end
    endtask

    task automatic wait_cs(input logic level, output bit ok);
        int n = 0;
        while (outDAC_CS_n !== level && n < 400) begin
            @(negedge inCLK_50MHZ);
            n++;
        end
        ok = (outDAC_CS_n === level);
    endtask

    task automatic test_reset;
        inRESET = 1'b1;
        repeat (3) @(negedge inCLK_50MHZ);
        vectors++;
        if ({outDAC_CS_n, outDAC_SCK, outDAC_MOSI, outBusy, outOverrun} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_outputs: got cs/sck/mosi/busy/ovr=%b expected 10000",
                     {outDAC_CS_n, outDAC_SCK, outDAC_MOSI, outBusy, outOverrun});
        end
        inRESET = 1'b0;
        @(negedge inCLK_50MHZ);
    endtask

    task automatic test_first_frame;
        bit ok; logic [15:0] f, e; int r, c, g, n;
        push_exp(12'h000);
        strobe(12'h000);
        vectors++;
        if (outDAC_CS_n !== 1'b0 || outBusy !== 1'b1) begin
            miscompares++;
            $display("FAIL cs_latency: got cs=%b busy=%b expected cs=0 busy=1", outDAC_CS_n, outBusy);
        end
        n = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge inCLK_50MHZ);
            if (outBusy !== 1'b1) break;
            n++;
        end
        vectors++;
        if (n != 136) begin
            miscompares++;
            $display("FAIL busy_length: got %0d expected 136", n);
        end
        get_frame(ok, f, r, c, g, e);
        vectors++;
        if (!ok || f !== e) begin
            miscompares++;
            $display("FAIL first_frame: got %h (ok=%0d) expected %h", f, ok, e);
        end
        vectors++;
        if (r != 16 || c != 132) begin
            miscompares++;
            $display("FAIL frame_timing: got rises=%0d cs_low=%0d expected 16 and 132", r, c);
        end
        vectors++;
        if (outDAC_MOSI !== 1'b0) begin
            miscompares++;
            $display("FAIL mosi_hold_0: got %b expected 0", outDAC_MOSI);
        end
    endtask

    task automatic test_codes;
        bit ok; logic [15:0] f, e; int r, c, g;
        logic [11:0] codes[2] = '{12'h7FF, 12'h801};
        logic        lastBit[2] = '{1'b1, 1'b1};
        foreach (codes[k]) begin
            push_exp(codes[k]);
            strobe(codes[k]);
            get_frame(ok, f, r, c, g, e);
            vectors++;
            if (!ok || f !== e || r != 16) begin
                miscompares++;
                $display("FAIL code_%h: got %h rises=%0d (ok=%0d) expected %h rises=16",
                         codes[k], f, r, ok, e);
            end
            repeat (10) @(negedge inCLK_50MHZ);
            vectors++;
            if (outDAC_MOSI !== lastBit[k]) begin
                miscompares++;
                $display("FAIL mosi_hold_%h: got %b expected %b", codes[k], outDAC_MOSI, lastBit[k]);
            end
        end
        vectors++;
        if (outOverrun !== 1'b0) begin
            miscompares++;
            $display("FAIL codes_overrun: got %b expected 0", outOverrun);
        end
    endtask

    task automatic test_back_to_back;
        bit ok; logic [15:0] f, e; int r, c, g;
        push_exp(12'h123);
        strobe(12'h123);
        repeat (9) @(negedge inCLK_50MHZ);
        push_exp(12'hABC);
        strobe(12'hABC);
        get_frame(ok, f, r, c, g, e);
        vectors++;
        if (!ok || f !== e) begin
            miscompares++;
            $display("FAIL b2b_first: got %h expected %h", f, e);
        end
        get_frame(ok, f, r, c, g, e);
        vectors++;
        if (!ok || f !== e || g != 5) begin
            miscompares++;
            $display("FAIL b2b_second: got %h gap=%0d expected %h gap=5", f, g, e);
        end
        vectors++;
        if (outOverrun !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_overrun: got %b expected 0", outOverrun);
        end
    endtask

    task automatic test_gap_strobe;
        bit ok, ok2; logic [15:0] f, e; int r, c, g;
        push_exp(12'h456);
        strobe(12'h456);
        wait_cs(1'b0, ok);
        wait_cs(1'b1, ok2);
        vectors++;
        if (!ok || !ok2) begin
            miscompares++;
            $display("FAIL gap_wait: got timeout expected CS_n toggle");
        end
        repeat (3) @(negedge inCLK_50MHZ);
        push_exp(12'hF00);
        strobe(12'hF00);
        vectors++;
        if (outBusy !== 1'b0 || outDAC_CS_n !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_idle: got busy=%b cs=%b expected busy=0 cs=1", outBusy, outDAC_CS_n);
        end
        @(negedge inCLK_50MHZ);
        vectors++;
        if (outBusy !== 1'b1 || outDAC_CS_n !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_restart: got busy=%b cs=%b expected busy=1 cs=0", outBusy, outDAC_CS_n);
        end
        get_frame(ok, f, r, c, g, e);
        get_frame(ok, f, r, c, g, e);
        vectors++;
        if (!ok || f !== e || g != 5) begin
            miscompares++;
            $display("FAIL gap_frame: got %h gap=%0d expected %h gap=5", f, g, e);
        end
    endtask

    task automatic test_overrun;
        bit ok; logic [15:0] f, e; int r, c, g;
        push_exp(12'h010);
        strobe(12'h010);
        repeat (9) @(negedge inCLK_50MHZ);
        strobe(12'h020);
        vectors++;
        if (outOverrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_early: got %b expected 0", outOverrun);
        end
        repeat (19) @(negedge inCLK_50MHZ);
        push_exp(12'h030);
        strobe(12'h030);
        vectors++;
        if (outOverrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got %b expected 1", outOverrun);
        end
        get_frame(ok, f, r, c, g, e);
        vectors++;
        if (!ok || f !== e) begin
            miscompares++;
            $display("FAIL overrun_a: got %h expected %h", f, e);
        end
        get_frame(ok, f, r, c, g, e);
        vectors++;
        if (!ok || f !== e) begin
            miscompares++;
            $display("FAIL overrun_c: got %h expected %h", f, e);
        end
        repeat (200) @(negedge inCLK_50MHZ);
        vectors++;
        if (gotFrame.size() != 0 || outOverrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_extra: got %0d frames ovr=%b expected 0 frames ovr=1",
                     gotFrame.size(), outOverrun);
        end
    endtask

    task automatic test_reset_midframe;
        bit ok; logic [15:0] f, e; int r, c, g, rises0;
        strobe(12'h555);
        wait_cs(1'b0, ok);
        repeat (50) @(negedge inCLK_50MHZ);
        inRESET = 1'b1;
        @(negedge inCLK_50MHZ);
        inRESET = 1'b0;
        vectors++;
        if ({outDAC_CS_n, outDAC_SCK, outDAC_MOSI, outBusy, outOverrun} !== 5'b10000) begin
            miscompares++;
            $display("FAIL midframe_reset: got cs/sck/mosi/busy/ovr=%b expected 10000",
                     {outDAC_CS_n, outDAC_SCK, outDAC_MOSI, outBusy, outOverrun});
        end
        rises0 = totalRises;
        repeat (200) @(negedge inCLK_50MHZ);
        vectors++;
        if (totalRises != rises0 || outBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_quiet: got %0d sck rises busy=%b expected 0 and 0",
                     totalRises - rises0, outBusy);
        end
        gotFrame.delete(); gotRises.delete(); gotCsLow.delete(); gotGap.delete(); expQ.delete();
        push_exp(12'h800);
        strobe(12'h800);
        get_frame(ok, f, r, c, g, e);
        vectors++;
        if (!ok || f !== e || r != 16) begin
            miscompares++;
            $display("FAIL recovery_frame: got %h rises=%0d expected %h rises=16", f, r, e);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_codes();
        test_back_to_back();
        test_gap_strobe();
        test_overrun();
        test_reset_midframe();
        vectors++;
        if (sckWhileIdle != 0) begin
            miscompares++;
            $display("FAIL sck_idle: got %0d cycles of SCK high with CS_n high expected 0", sckWhileIdle);
        end
`ifndef SAMPLE_DAC_LDAC_EN
        vectors++;
        if (ldacHigh != 0) begin
            miscompares++;
            $display("FAIL ldac_const: got %0d cycles LDAC_n high expected 0", ldacHigh);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
